// File: rtl/branch_redirect_ctrl_if.sv
// PC redirect handshake between the redirect controller (master) and fetch (slave).
interface branch_redirect_ctrl_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (output redirect_valid, redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, redirect_pc, output redirect_ready);
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Redirect/flush sequencer for EX-resolved branches and jumps.
// Optional performance counters are built when BRANCH_PERF_EN is defined.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jump,
    input  logic                  Branch,
    input  logic [XLEN-1:0]       ex_target,
    input  logic                  hz_stall,
    branch_redirect_ctrl_if.master rd,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  busy,
    output logic                  misalign_err,
    output logic [CNT_W-1:0]      perf_branches,
    output logic [CNT_W-1:0]      perf_taken
);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [XLEN-1:0] target_q, target_n, ex_pc;
    logic            take, accept;

    // Flush has priority over the load-use stall downstream, so the stall is not used here.
    logic unused_hz;
    assign unused_hz = hz_stall;

    assign busy         = (state != IDLE);
    // Gating with reset keeps the combinational outputs quiet while reset is held.
    assign take         = reset & ex_valid & ~busy & (ex_is_jump | (ex_is_branch & Branch));
    assign ex_pc        = {ex_target[XLEN-1:2], 2'b00};
    assign misalign_err = take & (ex_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            target_q <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            target_q <= target_n;
        end
    end

    always_comb begin
        state_n           = state;
        cnt_n             = cnt;
        target_n          = target_q;
        accept            = 1'b0;
        rd.redirect_valid = 1'b0;
        rd.redirect_pc    = '0;
        flush_if_id       = 1'b0;
        flush_id_ex       = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    rd.redirect_valid = 1'b1;
                    rd.redirect_pc    = ex_pc;
                    flush_if_id       = 1'b1;
                    flush_id_ex       = 1'b1;
                    target_n          = ex_pc;
                    accept            = rd.redirect_ready;
                    if (!rd.redirect_ready) state_n = REDIRECT;
                end
            end
            REDIRECT: begin
                rd.redirect_valid = 1'b1;
                rd.redirect_pc    = target_q;
                flush_if_id       = 1'b1;
                flush_id_ex       = 1'b1;
                accept            = rd.redirect_ready;
            end
            DRAIN: begin
                flush_if_id = 1'b1;
                cnt_n       = cnt - 4'd1;
                if (cnt == 4'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Once fetch takes the new PC, wrong-path fetches still need FLUSH_CYCLES of IF/ID squash.
        if (accept) begin
            if (FLUSH_CYCLES == 0) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                state_n = DRAIN;
                cnt_n   = 4'(FLUSH_CYCLES);
            end
        end
    end

`ifdef BRANCH_PERF_EN
    logic resolve;
    assign resolve = ex_valid & ~busy & (ex_is_branch | ex_is_jump);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_branches <= '0;
            perf_taken    <= '0;
        end else begin
            if (resolve && !(&perf_branches)) perf_branches <= perf_branches + 1'b1;
            if (take && !(&perf_taken))       perf_taken    <= perf_taken + 1'b1;
        end
    end
`else
    assign perf_branches = '0;
    assign perf_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (FLUSH_CYCLES=1 main DUT, FLUSH_CYCLES=0 side DUT).
module tb_branch_redirect_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
`ifdef BRANCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ex_valid, ex_is_branch, ex_is_jump, Branch, hz_stall;
    logic [XLEN-1:0] ex_target;
    logic flush_if_id, flush_id_ex, busy, misalign_err;
    logic [CNT_W-1:0] perf_branches, perf_taken;
    logic flush_if_id0, flush_id_ex0, busy0, misalign_err0;
    logic [CNT_W-1:0] perf_branches0, perf_taken0;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.XLEN(XLEN)) bus ();
    branch_redirect_ctrl_if #(.XLEN(XLEN)) bus0 ();
    assign bus0.redirect_ready = bus.redirect_ready;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .Branch(Branch), .ex_target(ex_target), .hz_stall(hz_stall),
        .rd(bus.master), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
        .misalign_err(misalign_err), .perf_branches(perf_branches), .perf_taken(perf_taken));

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .Branch(Branch), .ex_target(ex_target), .hz_stall(hz_stall),
        .rd(bus0.master), .flush_if_id(flush_if_id0), .flush_id_ex(flush_id_ex0), .busy(busy0),
        .misalign_err(misalign_err0), .perf_branches(perf_branches0), .perf_taken(perf_taken0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic [31:0] pc,
                           input logic fi, input logic fe, input logic bz, input logic mis);
        chk({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(rv));
        chk({tag, ".redirect_pc"},    64'(bus.redirect_pc),    64'(pc));
        chk({tag, ".flush_if_id"},    64'(flush_if_id),        64'(fi));
        chk({tag, ".flush_id_ex"},    64'(flush_id_ex),        64'(fe));
        chk({tag, ".busy"},           64'(busy),               64'(bz));
        chk({tag, ".misalign_err"},   64'(misalign_err),       64'(mis));
    endtask

    task automatic chk_perf(input string tag, input int eb, input int et);
        chk({tag, ".perf_branches"}, 64'(perf_branches), PERF_ON ? 64'(eb) : 64'd0);
        chk({tag, ".perf_taken"},    64'(perf_taken),    PERF_ON ? 64'(et) : 64'd0);
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; Branch = 1'b0;
        hz_stall = 1'b0; ex_target = '0; bus.redirect_ready = 1'b0;
    endtask

    task automatic branch_in(input logic [31:0] tgt, input logic rdy);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0; Branch = 1'b1;
        hz_stall = 1'b0; ex_target = tgt; bus.redirect_ready = rdy;
    endtask

    initial begin
        idle_in();
        // Reset held with random EX activity
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_valid = 1'($urandom); ex_is_branch = 1'($urandom); ex_is_jump = 1'($urandom);
            Branch = 1'($urandom); hz_stall = 1'($urandom); ex_target = $urandom;
            bus.redirect_ready = 1'($urandom);
            #2 chk_out("rst_rand", 0, 0, 0, 0, 0, 0);
            chk_perf("rst_rand", 0, 0);
        end
        @(negedge clk); idle_in(); reset = 1'b1;
        #2 chk_out("post_rst0", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 chk_out("post_rst1", 0, 0, 0, 0, 0, 0);

        // Taken beq, ready immediately
        @(negedge clk); branch_in(32'h100, 1'b1);
        #2 chk_out("beq_c0", 1, 32'h100, 1, 1, 0, 0);
        @(negedge clk); idle_in();
        #2 chk_out("beq_c1", 0, 0, 1, 0, 1, 0);
        chk("beq_c1.fc0_busy", 64'(busy0), 64'd0);
        chk("beq_c1.fc0_flush_if_id", 64'(flush_if_id0), 64'd0);
        @(negedge clk);
        #2 chk_out("beq_c2", 0, 0, 0, 0, 0, 0);
        chk_perf("beq", 1, 1);

        // Not-taken branch
        @(negedge clk); branch_in(32'h200, 1'b1); Branch = 1'b0;
        #2 chk_out("nt_c0", 0, 0, 0, 0, 0, 0);
        @(negedge clk); idle_in();
        #2 chk_out("nt_c1", 0, 0, 0, 0, 0, 0);
        chk_perf("nt", 2, 1);

        // Backpressure: 3 cycles not ready, second taken branch must be ignored
        @(negedge clk); branch_in(32'h2000, 1'b0);
        #2 chk_out("bp_c0", 1, 32'h2000, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); branch_in(32'h3001, 1'b0);
            #2 chk_out("bp_wait", 1, 32'h2000, 1, 1, 1, 0);
        end
        @(negedge clk); bus.redirect_ready = 1'b1;
        #2 chk_out("bp_acc", 1, 32'h2000, 1, 1, 1, 0);
        @(negedge clk); idle_in();
        #2 chk_out("bp_drain", 0, 0, 1, 0, 1, 0);
        chk("bp_drain.fc0_busy", 64'(busy0), 64'd0);
        @(negedge clk);
        #2 chk_out("bp_idle", 0, 0, 0, 0, 0, 0);
        chk_perf("bp", 3, 2);

        // Misaligned jalr, without and with a coincident load-use stall
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle_in();
            ex_valid = 1'b1; ex_is_jump = 1'b1; ex_target = 32'h103;
            bus.redirect_ready = 1'b1; hz_stall = 1'(k);
            #2 chk_out(k == 0 ? "jalr_c0" : "jalr_stall_c0", 1, 32'h100, 1, 1, 0, 1);
            @(negedge clk); idle_in();
            #2 chk_out(k == 0 ? "jalr_c1" : "jalr_stall_c1", 0, 0, 1, 0, 1, 0);
        end
        @(negedge clk);
        #2 chk_out("jalr_idle", 0, 0, 0, 0, 0, 0);
        chk_perf("jalr", 5, 4);

        // Asynchronous reset while in REDIRECT
        @(negedge clk); branch_in(32'h500, 1'b0);
        #2 chk_out("rr_c0", 1, 32'h500, 1, 1, 0, 0);
        @(negedge clk); idle_in();
        #2 chk_out("rr_c1", 1, 32'h500, 1, 1, 1, 0);
        #1 reset = 1'b0;
        #1 chk_out("rr_async", 0, 0, 0, 0, 0, 0);
        chk_perf("rr_async", 0, 0);
        @(negedge clk); reset = 1'b1;
        #2 chk_out("rr_rel", 0, 0, 0, 0, 0, 0);
        @(negedge clk); branch_in(32'h40, 1'b1);
        #2 chk_out("rr_new_c0", 1, 32'h40, 1, 1, 0, 0);
        @(negedge clk); idle_in();
        #2 chk_out("rr_new_c1", 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        #2 chk_out("rr_new_c2", 0, 0, 0, 0, 0, 0);
        chk_perf("rr_new", 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
